serial_parity_checker: RTL and testbench
========================================

# serial_parity_checker

- Receives a serial bit stream from the XOR parity stage one bit per cycle, LSB first.
- Each frame is WIDTH data bits followed by one parity bit.
- For each frame it accumulates the running XOR, reassembles the data word and checks parity.
- It presents the result on a valid/ready output port and keeps a saturating count of parity errors for the downstream status logic.

## Interface
- WIDTH, 8, data bits per frame (2..32)
- ODD, 0, parity sense: 0 = even (XOR of data+parity must be 0), 1 = odd (must be 1)
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- clear  input  1  synchronous frame abort; discards partial frame, keeps err_count
- bit_in  input  1  serial data/parity bit
- bit_valid  input  1  bit_in is valid this cycle
- bit_ready  output  1  block accepts a bit this cycle
- data_out  output  WIDTH  reassembled word, first received bit at bit 0
- parity_ok  output  1  1 = frame passed parity check
- out_valid  output  1  data_out/parity_ok valid
- out_ready  input  1  consumer takes result this cycle
- err_count  output  8  number of failed frames, saturates at 255

## Operation
- Accept condition: bit_valid && bit_ready.
- Transfer condition: out_valid && out_ready.
- States:
  - S_DATA (count 0..WIDTH-1)
  - S_PAR (expecting parity bit)
  - S_OUT (result held)
- Reset: state=S_DATA, count=0, acc=0, data_out=0, parity_ok=0, out_valid=0, err_count=0. bit_ready=1 in the first cycle after reset.
- bit_ready = 1 in S_DATA and S_PAR, 0 in S_OUT. It is a combinational decode of the registered state only, with no path from bit_valid.
- S_DATA, on accept:
  - shreg <= {bit_in, shreg[WIDTH-1:1]}
  - acc <= acc ^ bit_in
  - count <= count+1
  - when count==WIDTH-1, go to S_PAR.
- S_PAR, on accept:
  - data_out <= shreg
  - parity_ok <= ((acc ^ bit_in) == ODD)
  - out_valid <= 1
  - if the check fails and err_count<255, err_count increments.
  - go to S_OUT.
- S_OUT, on transfer: out_valid <= 0, acc <= 0, count <= 0, go to S_DATA.
- data_out and parity_ok hold their values until the next frame's parity bit is accepted; they are not cleared on transfer.
- clear:
  - in S_DATA or S_PAR: count=0, acc=0, state=S_DATA; the incoming bit that cycle is dropped.
  - in S_OUT: out_valid=0, state=S_DATA; the pending result is discarded and err_count is unchanged (already counted).
- Priority: reset > clear > normal operation.
- bit_valid=0 simply stalls; the partial frame is retained indefinitely.

## Timing
- All outputs are registered except bit_ready (state decode).
- Latency: out_valid rises on the first rising edge at which the parity bit is accepted, i.e. it is visible the cycle after the parity bit is presented.
- With bit_valid and out_ready tied high, a frame takes WIDTH+2 cycles: WIDTH+1 bits plus 1 output cycle with bit_ready=0.
- Backpressure: while out_ready=0, out_valid stays 1 and bit_ready stays 0. No bits are lost and no outputs change.
- Simultaneous accept and transfer cannot occur, because bit_ready=0 whenever out_valid=1.
- err_count updates in the same edge that sets out_valid.
- Saturation: at err_count=255, further failures leave it at 255.
- Reset mid-frame or mid-hold: all state returns to reset values on that edge, with no residual out_valid.

## Test plan
- **Good frame:** WIDTH=8, ODD=0. Feed 1,0,1,0,0,1,0,1 then parity 0, out_ready=1. Require: data_out=0xA5, parity_ok=1, err_count=0, out_valid high for exactly 1 cycle, next frame's first bit accepted 10 cycles after the first bit.
- **Bad frame:** feed 0x07 (1,1,1,0,0,0,0,0) with parity 0. Require: parity_ok=0, err_count=1. Repeat with parity 1: parity_ok=1, err_count stays 1.
- **Backpressure:** hold out_ready=0 for 5 cycles after the result while bit_valid=1. Require: bit_ready=0, out_valid=1, data_out stable throughout. A frame 0x3C sent afterwards decodes correctly.
- **Clear mid-frame:** clear after 3 data bits, then a full 0x5A frame with parity 0. Require: data_out=0x5A, parity_ok=1. Clear while in S_OUT: out_valid drops the next cycle and err_count is unchanged.
- **Saturation:** send 260 bad frames. Require: err_count=255 after frame 255 and still 255 after 260.
- **Reset mid-frame:** reset after 5 bits, then send 0xFF with parity 0. Require: all outputs 0 after reset, then data_out=0xFF, parity_ok=1. Repeat with ODD=1 and 0xFF, parity 1: parity_ok=1.

Source files
------------

// File: rtl/serial_parity_checker.sv
// Serial parity checker: deserialises LSB-first frames of WIDTH data bits
// plus one parity bit, checks parity and counts failed frames (saturating).
module serial_parity_checker #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             parity_ok,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       err_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_PAR  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    count;
  logic             acc;
  logic [WIDTH-1:0] shreg;
  logic             accept;
  logic             xfer;
  logic             par_ok_nxt;

  // Ready depends on registered state only, never on bit_valid.
  assign bit_ready  = (state != S_OUT);
  assign accept     = bit_valid & bit_ready;
  assign xfer       = out_valid & out_ready;
  assign par_ok_nxt = ((acc ^ bit_in) == ODD);

  always_ff @(posedge clk) begin
    if (reset) state <= S_DATA;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_DATA: begin
        if (clear)
          state_nxt = S_DATA;
        else if (accept && count == LAST)
          state_nxt = S_PAR;
      end
      S_PAR: begin
        if (clear)
          state_nxt = S_DATA;
        else if (accept)
          state_nxt = S_OUT;
      end
      S_OUT: begin
        if (clear || xfer)
          state_nxt = S_DATA;
      end
      default: state_nxt = S_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      acc       <= 1'b0;
      shreg     <= '0;
      data_out  <= '0;
      parity_ok <= 1'b0;
      out_valid <= 1'b0;
      err_count <= 8'd0;
    end else if (clear) begin
      // Abort: partial frame or pending result dropped, errors kept.
      count     <= '0;
      acc       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_DATA: begin
          if (accept) begin
            shreg <= {bit_in, shreg[WIDTH-1:1]};
            acc   <= acc ^ bit_in;
            count <= count + 1'b1;
          end
        end
        S_PAR: begin
          if (accept) begin
            data_out  <= shreg;
            parity_ok <= par_ok_nxt;
            out_valid <= 1'b1;
            if (!par_ok_nxt && err_count != 8'hFF)
              err_count <= err_count + 8'd1;
          end
        end
        S_OUT: begin
          if (xfer) begin
            out_valid <= 1'b0;
            acc       <= 1'b0;
            count     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Randomised bench for serial_parity_checker: even and odd instances share
// one stimulus stream and are checked against a frame-level model.
module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       br_e, ok_e, ov_e;
  logic [7:0] do_e, ec_e;
  logic       br_o, ok_o, ov_o;
  logic [7:0] do_o, ec_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] exp_data;
  logic       exp_ok [2];
  int         exp_err [2];

  serial_parity_checker #(.WIDTH(8), .ODD(1'b0)) dut_even (
    .clk(clk), .reset(reset), .clear(clear),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(br_e),
    .data_out(do_e), .parity_ok(ok_e), .out_valid(ov_e),
    .out_ready(out_ready), .err_count(ec_e)
  );

  serial_parity_checker #(.WIDTH(8), .ODD(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .clear(clear),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(br_o),
    .data_out(do_o), .parity_ok(ok_o), .out_valid(ov_o),
    .out_ready(out_ready), .err_count(ec_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_data = 8'h00;
    for (int k = 0; k < 2; k++) begin
      exp_ok[k]  = 1'b0;
      exp_err[k] = 0;
    end
  endtask

  // Frame rule: XOR of all nine bits must equal the parity sense.
  task automatic model_frame(input logic [7:0] d, input logic p);
    exp_data = d;
    for (int k = 0; k < 2; k++) begin
      bit ok;
      ok = (((^d) ^ p) == (k == 1));
      exp_ok[k] = ok;
      if (!ok && exp_err[k] < 255) exp_err[k]++;
    end
  endtask

  task automatic check_outs(input string tag, input logic vld);
    check({tag, ".ov_e"}, ov_e, vld);
    check({tag, ".ov_o"}, ov_o, vld);
    check({tag, ".do_e"}, do_e, exp_data);
    check({tag, ".do_o"}, do_o, exp_data);
    check({tag, ".ok_e"}, ok_e, exp_ok[0]);
    check({tag, ".ok_o"}, ok_o, exp_ok[1]);
    check({tag, ".ec_e"}, ec_e, exp_err[0]);
    check({tag, ".ec_o"}, ec_o, exp_err[1]);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!br_e && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("ready_timeout", br_e, 1);
  endtask

  task automatic send_bits(input logic [8:0] bits, input int n,
                           input bit gaps, output int first_cyc);
    first_cyc = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
        tick();
      end
      bit_in    = bits[i];
      bit_valid = 1'b1;
      wait_ready();
      if (i == 0) first_cyc = cyc;
      tick();
    end
    bit_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input int hold, input bit gaps,
                            input bit drop, input string tag,
                            output int fc);
    send_bits({p, d}, 9, gaps, fc);
    model_frame(d, p);
    check_outs({tag, ".res"}, 1'b1);
    check({tag, ".br_busy"}, br_e, 0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      bit_valid = 1'b1;
      bit_in    = 1'($urandom);
      tick();
      check({tag, ".bp_br"}, br_o, 0);
      check_outs({tag, ".bp"}, 1'b1);
    end
    bit_valid = 1'b0;
    if (drop) begin
      out_ready = 1'b0;
      clear     = 1'b1;
      tick();
      clear = 1'b0;
      check_outs({tag, ".drop"}, 1'b0);
    end else begin
      out_ready = 1'b1;
      tick();
      check_outs({tag, ".xfer"}, 1'b0);
    end
    check({tag, ".br_free"}, br_e, 1);
    out_ready = 1'b1;
  endtask

  initial begin
    int fc1, fc2, dummy;
    logic [7:0] d;
    model_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check_outs("reset", 1'b0);
    check("reset.br", br_e, 1);

    send_frame(8'hA5, 1'b0, 0, 1'b0, 1'b0, "good", fc1);
    send_frame(8'h07, 1'b0, 0, 1'b0, 1'b0, "bad0", fc2);
    check("frame_period", fc2 - fc1, 10);
    send_frame(8'h07, 1'b1, 0, 1'b0, 1'b0, "bad1", dummy);

    send_frame(8'($urandom), 1'($urandom), 5, 1'b0, 1'b0, "bp", dummy);
    send_frame(8'h3C, 1'b0, 0, 1'b0, 1'b0, "post_bp", dummy);

    send_bits(9'h0B5, 3, 1'b0, dummy);
    clear     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    tick();
    clear     = 1'b0;
    bit_valid = 1'b0;
    check_outs("clr_mid", 1'b0);
    send_frame(8'h5A, 1'b0, 0, 1'b0, 1'b0, "after_clr", dummy);
    send_frame(8'h07, 1'b0, 2, 1'b0, 1'b1, "clr_out", dummy);
    send_frame(8'h81, 1'b0, 0, 1'b0, 1'b0, "after_drop", dummy);

    for (int i = 0; i < 40; i++)
      send_frame(8'($urandom), 1'($urandom), $urandom_range(0, 3),
                 1'b1, $urandom_range(0, 7) == 0, "rnd", dummy);

    send_bits(9'h1FF, 9, 1'b0, dummy);
    out_ready = 1'b0;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    model_reset();
    check_outs("rst_hold", 1'b0);
    check("rst_hold.br", br_e, 1);

    for (int i = 0; i < 260; i++) begin
      d = 8'($urandom);
      send_frame(d, ~(^d), 0, 1'b0, 1'b0, "sat", dummy);
      if (i == 253) check("sat254", ec_e, 254);
      if (i == 254) check("sat255", ec_e, 255);
    end
    check("sat260", ec_e, 255);
    check("sat260_odd", ec_o, 0);

    send_bits(9'h0FF, 5, 1'b0, dummy);
    bit_valid = 1'b1;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    bit_valid = 1'b0;
    model_reset();
    check_outs("rst_mid", 1'b0);
    check("rst_mid.br", br_e, 1);
    send_frame(8'hFF, 1'b0, 0, 1'b0, 1'b0, "ff_p0", dummy);
    send_frame(8'hFF, 1'b1, 0, 1'b0, 1'b0, "ff_p1", dummy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
